output_writeback_controller: RTL and testbench

//  Counterpart of the input transfer path: accepts the conv result stream (valid/ready), buffers it
//  in a small FIFO and writes it into the output feature BRAM in raster order (col, row, channel).
//  It sits between the PE/accumulator array and the output BRAM, and signals completion of a

---
 rtl/output_writeback_controller.sv | 159 +++++++++++++++
 tb/tb_output_writeback_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/output_writeback_controller.sv
// Buffers the conv result stream in a small FIFO and writes it into the output
// feature BRAM in raster order, pulsing o_done at the end of each channel group.
module output_writeback_controller #(
    parameter int DATA_WIDTH                = 32,
    parameter int OUTPUT_BRAM_DEPTH         = 224*224,
    parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
    parameter int OUTPUT_ROW_WIDTH          = 6,
    parameter int OUTPUT_COL_WIDTH          = 6,
    parameter int OUTPUT_CHANNEL_WIDTH      = 8,
    parameter int FIFO_DEPTH                = 8,
    parameter int TOTAL_WIDTH               = OUTPUT_ROW_WIDTH + OUTPUT_COL_WIDTH + OUTPUT_CHANNEL_WIDTH + 1
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_start,
    input  logic [OUTPUT_ROW_WIDTH-1:0]          i_output_row,
    input  logic [OUTPUT_COL_WIDTH-1:0]          i_output_col,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_channel_start,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_channel_end,
    input  logic                                 i_result_valid,
    input  logic [DATA_WIDTH-1:0]                i_result_data,
    output logic                                 o_result_ready,
    input  logic                                 i_bram_busy,
    output logic                                 o_bram_wenable,
    output logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] o_bram_waddress,
    output logic [DATA_WIDTH-1:0]                o_bram_wdata,
    output logic                                 o_fifo_full,
    output logic                                 o_fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]          o_element_count,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_range_error
);

    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int RC_W   = OUTPUT_ROW_WIDTH + OUTPUT_COL_WIDTH;
    localparam int BASE_W = RC_W + OUTPUT_CHANNEL_WIDTH;
    localparam int SUM_W  = ((BASE_W > TOTAL_WIDTH) ? BASE_W : TOTAL_WIDTH) + 1;
    localparam int AW     = OUTPUT_BRAM_ADDRESS_WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic [OUTPUT_ROW_WIDTH-1:0]     row_q;
    logic [OUTPUT_COL_WIDTH-1:0]     col_q;
    logic [OUTPUT_CHANNEL_WIDTH-1:0] ch_start_q, ch_end_q;
    logic [TOTAL_WIDTH-1:0]          total_q, accepted, written;
    logic [AW-1:0]                   wr_addr;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;

    // Job geometry, widened so no product or sum can overflow before the range check
    logic [RC_W-1:0]                 rc;
    logic [OUTPUT_CHANNEL_WIDTH:0]   ch_span;
    logic [TOTAL_WIDTH-1:0]          total_calc;
    logic [BASE_W-1:0]               base_calc;
    logic [SUM_W-1:0]                end_calc;
    logic                            zero_job, over_range;

    assign rc         = RC_W'(row_q) * RC_W'(col_q);
    assign ch_span    = {1'b0, ch_end_q} - {1'b0, ch_start_q} + (OUTPUT_CHANNEL_WIDTH+1)'(1);
    assign total_calc = TOTAL_WIDTH'(rc) * TOTAL_WIDTH'(ch_span);
    assign base_calc  = BASE_W'(ch_start_q) * BASE_W'(rc);
    assign end_calc   = SUM_W'(base_calc) + SUM_W'(total_calc);
    assign zero_job   = (row_q == '0) || (col_q == '0) || (ch_end_q < ch_start_q);
    assign over_range = end_calc > SUM_W'(OUTPUT_BRAM_DEPTH);

    logic push, pop, last_push;

    assign o_fifo_full     = (count == (PW+1)'(FIFO_DEPTH));
    assign o_fifo_empty    = (count == '0);
    assign o_element_count = count;
    assign push            = i_result_valid && o_result_ready;
    assign pop             = ((state == RUN) || (state == DRAIN)) && !o_fifo_empty && !i_bram_busy;
    assign last_push       = push && ((accepted + TOTAL_WIDTH'(1)) == total_q);

    always_comb begin
        state_next     = state;
        o_result_ready = 1'b0;
        o_busy         = (state != IDLE);
        o_done         = 1'b0;
        case (state)
            IDLE:    if (i_start) state_next = LOAD;
            LOAD:    state_next = (zero_job || over_range) ? DONE : RUN;
            RUN: begin
                o_result_ready = !o_fifo_full;
                if (last_push) state_next = DRAIN;
            end
            DRAIN:   if ((written == total_q) && o_fifo_empty) state_next = DONE;
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr] <= i_result_data;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            row_q           <= '0;
            col_q           <= '0;
            ch_start_q      <= '0;
            ch_end_q        <= '0;
            total_q         <= '0;
            accepted        <= '0;
            written         <= '0;
            wr_addr         <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            o_range_error   <= 1'b0;
            o_bram_wenable  <= 1'b0;
            o_bram_waddress <= '0;
            o_bram_wdata    <= '0;
        end else begin
            state          <= state_next;
            o_bram_wenable <= pop;
            if ((state == IDLE) && i_start) begin
                row_q         <= i_output_row;
                col_q         <= i_output_col;
                ch_start_q    <= i_channel_start;
                ch_end_q      <= i_channel_end;
                o_range_error <= 1'b0;
            end
            if (state == LOAD) begin
                total_q  <= total_calc;
                wr_addr  <= AW'(base_calc);
                accepted <= '0;
                written  <= '0;
                if (!zero_job && over_range) o_range_error <= 1'b1;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                accepted <= accepted + TOTAL_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + PW'(1);
                wr_addr         <= wr_addr + AW'(1);
                written         <= written + TOTAL_WIDTH'(1);
                o_bram_waddress <= wr_addr;
                o_bram_wdata    <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_output_writeback_controller.sv
// Directed bench for output_writeback_controller on a 64-word BRAM; writes are
// collected per job and compared against hand-derived address/data sequences.
module tb_output_writeback_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [5:0]  i_output_row, i_output_col;
    logic [7:0]  i_channel_start, i_channel_end;
    logic        i_result_valid;
    logic [31:0] i_result_data;
    logic        o_result_ready;
    logic        i_bram_busy;
    logic        o_bram_wenable;
    logic [5:0]  o_bram_waddress;
    logic [31:0] o_bram_wdata;
    logic        o_fifo_full, o_fifo_empty;
    logic [3:0]  o_element_count;
    logic        o_busy, o_done, o_range_error;

    output_writeback_controller #(.OUTPUT_BRAM_DEPTH(64)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(i_start),
        .i_output_row(i_output_row), .i_output_col(i_output_col),
        .i_channel_start(i_channel_start), .i_channel_end(i_channel_end),
        .i_result_valid(i_result_valid), .i_result_data(i_result_data),
        .o_result_ready(o_result_ready), .i_bram_busy(i_bram_busy),
        .o_bram_wenable(o_bram_wenable), .o_bram_waddress(o_bram_waddress),
        .o_bram_wdata(o_bram_wdata), .o_fifo_full(o_fifo_full),
        .o_fifo_empty(o_fifo_empty), .o_element_count(o_element_count),
        .o_busy(o_busy), .o_done(o_done), .o_range_error(o_range_error)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          wa[$];
    logic [31:0] wd[$];
    int          done_cnt, busy_cyc, max_cnt, viol, cycles, first_wr;
    bit          timed_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset image is 'h80: only o_fifo_empty set
    function automatic logic [63:0] outs();
        return {15'd0, o_bram_wdata, o_bram_waddress, o_bram_wenable, o_result_ready,
                o_fifo_full, o_fifo_empty, o_element_count, o_busy, o_done, o_range_error};
    endfunction

    // mode 0: valid always; 1: busy 10 cycles from first write; 2: reset after 5th write;
    // 3: random valid/busy plus a stray i_start mid-job with altered geometry
    task automatic run_job(input int r, input int c, input int cs, input int ce,
                           input int mode, input logic [31:0] dbase);
        int  n, busy_left, k;
        bit  busy_used;
        n = 0; busy_left = 0; busy_used = 0;
        wa.delete(); wd.delete();
        done_cnt = 0; busy_cyc = 0; max_cnt = 0; viol = 0; first_wr = -1; timed_out = 1;
        @(negedge clk);
        i_output_row = r[5:0]; i_output_col = c[5:0];
        i_channel_start = cs[7:0]; i_channel_end = ce[7:0];
        i_start = 1'b1; i_result_valid = 1'b0; i_bram_busy = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        if (mode == 3) i_output_row = 6'd1;
        for (k = 0; k < 2000; k++) begin
            if (o_bram_wenable) begin
                if (first_wr < 0) first_wr = k;
                wa.push_back(int'(o_bram_waddress));
                wd.push_back(o_bram_wdata);
            end
            if (o_busy) busy_cyc++;
            if (int'(o_element_count) > max_cnt) max_cnt = int'(o_element_count);
            if (o_fifo_full && o_result_ready) viol++;
            if (o_done) begin done_cnt++; timed_out = 0; break; end
            if (mode == 2 && wa.size() == 5) begin rst = 1'b1; timed_out = 0; break; end
            i_start        = (mode == 3 && k == 5);
            i_result_valid = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 1) begin
                if (wa.size() > 0 && !busy_used) begin busy_left = 10; busy_used = 1; end
                i_bram_busy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
            end else begin
                i_bram_busy = (mode == 3) ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            i_result_data = dbase + 32'(n);
            if (i_result_valid && o_result_ready) n++;
            @(negedge clk);
        end
        cycles = k;
        i_result_valid = 1'b0; i_bram_busy = 1'b0; i_start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int base, input int total,
                                input logic [31:0] dbase);
        int bad;
        bad = 0;
        chk({tag, "_count"}, wa.size(), total);
        for (int i = 0; i < wa.size() && i < total; i++)
            if (wa[i] != base + i || wd[i] != dbase + 32'(i)) bad++;
        chk({tag, "_order"}, bad, 0);
    endtask

    initial begin
        rst = 1'b1; i_start = 0; i_output_row = 0; i_output_col = 0;
        i_channel_start = 0; i_channel_end = 0; i_result_valid = 0;
        i_result_data = 0; i_bram_busy = 0;
        #1 chk("reset_state", outs(), 64'h80);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 2x3, channels 1..2: base 6, 12 words
        run_job(2, 3, 1, 2, 0, 32'hA000);
        chk("a_timeout", timed_out, 0);
        chk("a_done", done_cnt, 1);
        check_writes("a", 6, 12, 32'hA000);
        chk("a_latency", first_wr, 3);
        chk("a_cycles", cycles, 15);
        chk("a_range", o_range_error, 0);
        @(negedge clk);
        chk("a_idle", {o_busy, o_done, o_fifo_empty}, 3'b001);

        run_job(2, 3, 1, 2, 1, 32'hB000);
        chk("b_timeout", timed_out, 0);
        check_writes("b", 6, 12, 32'hB000);
        chk("b_max_count", max_cnt, 8);
        chk("b_ready_when_full", viol, 0);

        run_job(0, 3, 0, 0, 0, 32'hC000);
        chk("r0_done_latency", cycles, 1);
        chk("r0_busy_cycles", busy_cyc, 2);
        chk("r0_writes", wa.size(), 0);
        run_job(2, 2, 5, 3, 0, 32'hC100);
        chk("rev_done_latency", cycles, 1);
        chk("rev_busy_cycles", busy_cyc, 2);
        chk("rev_writes", wa.size(), 0);

        // base 48 + 32 words > 64
        run_job(4, 4, 3, 4, 0, 32'hD000);
        chk("over_done", done_cnt, 1);
        chk("over_writes", wa.size(), 0);
        @(negedge clk); @(negedge clk);
        chk("over_sticky", o_range_error, 1);
        // base 32 + 32 words lands exactly on the BRAM end
        run_job(4, 4, 2, 3, 0, 32'hE000);
        chk("edge_range_clear", o_range_error, 0);
        check_writes("edge", 32, 32, 32'hE000);

        run_job(2, 3, 1, 2, 2, 32'h1000);
        check_writes("pre_reset", 6, 5, 32'h1000);
        #1 chk("mid_reset_outputs", outs(), 64'h80);
        @(negedge clk);
        chk("mid_reset_hold", outs(), 64'h80);
        rst = 1'b0;
        run_job(2, 3, 1, 2, 0, 32'h2000);
        chk("restart_done", done_cnt, 1);
        check_writes("restart", 6, 12, 32'h2000);

        run_job(4, 4, 0, 2, 3, 32'h3000);
        chk("rand_timeout", timed_out, 0);
        check_writes("rand", 0, 48, 32'h3000);
        chk("rand_count_bound", max_cnt <= 8, 1);
        chk("rand_ready_when_full", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
